input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
Multi-channel conditioner for asynchronous inputs such as buttons, switches and external strobes. Each channel goes through a parametrised-depth flip-flop synchronizer, then an optional saturating-count debouncer, then a rising/falling edge detector. It sits between the board I/O pins and the user logic. It supplies the raw synchronised level, the debounced level, and single-cycle edge pulses per channel.

Parameters:
WIDTH, 1, number of independent channels.
SYNC_STAGES, 2, synchronizer flops per channel; must be >= 2.
SAMPLE_CNT_MAX, 62500, clk cycles per debounce sample tick; must be >= 1.
PULSE_CNT_MAX, 200, consecutive high sample ticks required to assert the debounced level; must be >= 1.
DEBOUNCE_EN, 1, 1 enables the debouncer; 0 bypasses it (level_out equals sync_out).

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
async_in  input  WIDTH  asynchronous inputs.
sync_out  output  WIDTH  synchronised copy of async_in (last synchronizer stage).
level_out  output  WIDTH  debounced level.
rise_pulse  output  WIDTH  one-cycle pulse on each 0->1 transition of level_out.
fall_pulse  output  WIDTH  one-cycle pulse on each 1->0 transition of level_out.

Behaviour:
- Reset: rst is sampled on the clk rising edge only. On reset, every synchronizer stage, the sample counter, all channel counters and all previous-level registers clear to 0. All outputs are therefore 0 in the cycle after rst is sampled high. A reset does not generate a fall_pulse, even if level_out was 1.
- Synchronizer: a chain of SYNC_STAGES registers per bit, with no logic between stages. sync_out drives straight from the last stage. Latency: a change stable before edge k appears on sync_out after edge k+SYNC_STAGES-1.
- Sample counter: one counter shared by all channels, width clog2(SAMPLE_CNT_MAX), range 0..SAMPLE_CNT_MAX-1. It wraps to 0 after SAMPLE_CNT_MAX-1. sample_tick = (counter == SAMPLE_CNT_MAX-1). With SAMPLE_CNT_MAX=1, sample_tick is high every cycle.
- Channel counter i: width clog2(PULSE_CNT_MAX+1). Next-state priority:
  (1) rst -> 0;
  (2) sync_out[i]==0 -> 0 (clears on every cycle, not only on ticks);
  (3) sample_tick and count < PULSE_CNT_MAX -> count+1;
  (4) otherwise hold, saturating at PULSE_CNT_MAX.
- A sample_tick in the same cycle as sync_out[i]==0 clears the counter (clear wins).
- level_out[i] = (count_i == PULSE_CNT_MAX), decoded from registered state with no input-to-output combinational path.
- With DEBOUNCE_EN=0: level_out = sync_out, and the counters are removed or unused.
- Edge detect: prev[i] <= level_out[i] each cycle.
  - rise_pulse[i] = level_out[i] & ~prev[i].
  - fall_pulse[i] = ~level_out[i] & prev[i].
  - Each pulse lasts exactly one cycle per transition; rise and fall are never high together.
- Assert latency (debounced): level_out rises between SYNC_STAGES+(PULSE_CNT_MAX-1)*SAMPLE_CNT_MAX+1 and SYNC_STAGES+PULSE_CNT_MAX*SAMPLE_CNT_MAX edges after a clean async rise.
- Release latency: level_out falls SYNC_STAGES+1 edges after async_in falls. There is no debounce on release.
- A high glitch that yields fewer than PULSE_CNT_MAX ticks while sync is high never asserts level_out.
- Channels are fully independent except for the shared sample_tick.

Test Plan:
All scenarios use WIDTH=2, SYNC_STAGES=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, DEBOUNCE_EN=1 unless stated.
1. Reset: rst high for 2 cycles with async_in=2'b11 -> sync_out, level_out, rise_pulse and fall_pulse all 0 while rst is high. After release, sync_out=2'b11 at the 2nd edge.
2. Clean press: async_in[0] 0->1 and held -> sync_out[0]=1 at edge 2; level_out[0]=1 at an edge in 11..14; rise_pulse[0]=1 for exactly that one cycle; channel 1 stays 0.
3. Glitch rejection: async_in[0] high for 5 cycles, then low -> level_out[0], rise_pulse[0] and fall_pulse[0] stay 0 throughout.
4. Release: from level_out[0]=1, drop async_in[0] -> level_out[0]=0 at edge 3 and fall_pulse[0]=1 for that single cycle. Re-press -> full 11..14 cycle latency again, since the counter restarted from 0.
5. Bounce: toggle async_in[1] every 3 cycles for 40 cycles, then hold high -> no rise_pulse[1] during toggling; exactly one rise_pulse[1] after the hold satisfies the latency bound.
6. Bypass and mid-operation reset: with DEBOUNCE_EN=0, async_in[0] rise -> level_out[0] and rise_pulse[0] at edge 2. Asserting rst while level_out[0]=1 -> level_out[0]=0 next cycle with no fall_pulse[0].

Source files
------------

// File: rtl/input_conditioner.sv
// Per-channel input conditioning: N-flop synchronizer, optional saturating-count
// debouncer driven by a shared sample tick, and rise/fall edge pulses.
module input_conditioner #(
  parameter int WIDTH          = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200,
  parameter int DEBOUNCE_EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_EN != 0) begin : g_debounce
      // A 1-cycle sample period still needs a 1-bit counter that never leaves 0.
      localparam int SW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
      localparam int CW = $clog2(PULSE_CNT_MAX + 1);
      localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
      localparam logic [CW-1:0] COUNT_MAX   = CW'(PULSE_CNT_MAX);

      logic [SW-1:0] sample_cnt;
      logic          sample_tick;
      logic [CW-1:0] cnt [WIDTH];

      assign sample_tick = (sample_cnt == SAMPLE_LAST);

      always_ff @(posedge clk) begin
        if (rst || sample_tick) sample_cnt <= '0;
        else                    sample_cnt <= sample_cnt + SW'(1);
      end

      // A low synchronized level clears on any cycle, so only an unbroken high run counts.
      always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (rst || !sync_out[i])                  cnt[i] <= '0;
          else if (sample_tick && cnt[i] < COUNT_MAX) cnt[i] <= cnt[i] + CW'(1);
        end
      end

      always_comb begin
        level = '0;
        for (int unsigned i = 0; i < WIDTH; i++) level[i] = (cnt[i] == COUNT_MAX);
      end
    end else begin : g_bypass
      assign level = sync_out;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) prev <= '0;
    else     prev <= level;
  end

  assign level_out  = level;
  assign rise_pulse = level & ~prev;
  assign fall_pulse = ~level & prev;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: a debounced and a bypass instance share stimulus
// and are checked every cycle against a behavioural model, plus directed checks.
module tb_input_conditioner;

  localparam int W    = 2;
  localparam int SS   = 2;
  localparam int SMAX = 4;
  localparam int PMAX = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] async_in = '0;
  logic [W-1:0] d_sync, d_lvl, d_rise, d_fall;
  logic [W-1:0] b_sync, b_lvl, b_rise, b_fall;

  input_conditioner #(.WIDTH(W), .SYNC_STAGES(SS), .SAMPLE_CNT_MAX(SMAX),
                      .PULSE_CNT_MAX(PMAX), .DEBOUNCE_EN(1)) dut (
    .clk(clk), .rst(rst), .async_in(async_in), .sync_out(d_sync),
    .level_out(d_lvl), .rise_pulse(d_rise), .fall_pulse(d_fall));

  input_conditioner #(.WIDTH(W), .SYNC_STAGES(SS), .SAMPLE_CNT_MAX(SMAX),
                      .PULSE_CNT_MAX(PMAX), .DEBOUNCE_EN(0)) dut_byp (
    .clk(clk), .rst(rst), .async_in(async_in), .sync_out(b_sync),
    .level_out(b_lvl), .rise_pulse(b_rise), .fall_pulse(b_fall));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    tests++;
    if (v < lo || v > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, v, lo, hi, cyc);
    end
  endtask

  // Behavioural model: input delay line, ticks seen during an unbroken high run,
  // and edges derived from the level before/after each clock.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_sync, m_lvl, m_rise, m_fall, m_brise, m_bfall;
  logic [W-1:0] old_sync, old_lvl, new_lvl;
  int           since_rst;
  int           ticks_high [W];
  bit           m_tick;
  bit           mvalid = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mvalid = 1'b1;
      mq.delete();
      for (int k = 0; k < SS; k++) mq.push_back('0);
      since_rst = 0;
      for (int i = 0; i < W; i++) ticks_high[i] = 0;
      m_sync = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_brise = '0; m_bfall = '0;
    end else begin
      m_tick   = ((since_rst % SMAX) == SMAX - 1);
      since_rst++;
      old_sync = m_sync;
      old_lvl  = m_lvl;
      for (int i = 0; i < W; i++) begin
        if (!old_sync[i]) ticks_high[i] = 0;
        else if (m_tick)  ticks_high[i]++;
        new_lvl[i] = (ticks_high[i] >= PMAX);
      end
      mq.push_back(async_in);
      void'(mq.pop_front());
      m_sync  = mq[0];
      m_rise  = new_lvl & ~old_lvl;
      m_fall  = ~new_lvl & old_lvl;
      m_lvl   = new_lvl;
      m_brise = m_sync & ~old_sync;
      m_bfall = ~m_sync & old_sync;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("sync",      d_sync, m_sync);
      check("level",     d_lvl,  m_lvl);
      check("rise",      d_rise, m_rise);
      check("fall",      d_fall, m_fall);
      check("byp_sync",  b_sync, m_sync);
      check("byp_level", b_lvl,  m_sync);
      check("byp_rise",  b_rise, m_brise);
      check("byp_fall",  b_fall, m_bfall);
    end
  end

  // Called at a negedge right after the input rises; returns edges until level_out rises.
  task automatic measure_rise(input int ch, output int edges, output int rises);
    edges = 0;
    rises = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); @(negedge clk);
      if (d_rise[ch]) rises++;
      if (d_lvl[ch]) begin
        edges = k;
        break;
      end
    end
  endtask

  int edges, rises, seen;
  logic [W-1:0] v;

  initial begin
    // Reset with inputs high
    async_in = 2'b11;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check("rst_sync",  d_sync, 2'b00);
      check("rst_level", d_lvl,  2'b00);
      check("rst_rise",  d_rise, 2'b00);
      check("rst_fall",  d_fall, 2'b00);
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post_rst_sync_e1", d_sync, 2'b00);
    @(posedge clk); @(negedge clk);
    check("post_rst_sync_e2", d_sync, 2'b11);
    async_in = 2'b00;
    repeat (10) @(negedge clk);

    // Glitch rejection: 5 high cycles give at most 2 ticks
    async_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    async_in[0] = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      seen += int'(d_lvl[0]) + int'(d_rise[0]) + int'(d_fall[0]);
    end
    check_range("glitch_activity", seen, 0, 0);

    // Clean press
    async_in[0] = 1'b1;
    edges = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 1) check("press_sync_e1", {1'b0, d_sync[0]}, 2'b00);
      if (k == 2) begin
        check("press_sync_e2", {1'b0, d_sync[0]}, 2'b01);
        check("byp_level_e2",  {1'b0, b_lvl[0]},  2'b01);
        check("byp_rise_e2",   {1'b0, b_rise[0]}, 2'b01);
      end
      if (d_lvl[0]) begin
        edges = k;
        check("press_rise", {1'b0, d_rise[0]}, 2'b01);
        break;
      end
    end
    check_range("press_latency", edges, 11, 14);
    @(posedge clk); @(negedge clk);
    check("press_rise_once", {1'b0, d_rise[0]}, 2'b00);
    check("press_ch1_quiet", {1'b0, d_lvl[1]},  2'b00);

    // Release and re-press
    async_in[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 2) check("release_level_e2", {1'b0, d_lvl[0]}, 2'b01);
      if (k == 3) begin
        check("release_level_e3", {1'b0, d_lvl[0]},  2'b00);
        check("release_fall_e3",  {1'b0, d_fall[0]}, 2'b01);
      end
      if (k == 4) check("release_fall_once", {1'b0, d_fall[0]}, 2'b00);
    end
    async_in[0] = 1'b1;
    measure_rise(0, edges, rises);
    check_range("repress_latency", edges, 11, 14);
    check_range("repress_rises", rises, 1, 1);

    // Bounce on channel 1: 3-cycle highs never reach 3 ticks
    seen = 0;
    for (int t = 0; t < 14; t++) begin
      async_in[1] = ~async_in[1];
      repeat (3) begin
        @(posedge clk); @(negedge clk);
        seen += int'(d_rise[1]);
      end
    end
    check_range("bounce_rises", seen, 0, 0);
    async_in[1] = 1'b1;
    measure_rise(1, edges, rises);
    check_range("bounce_hold_latency", edges, 11, 14);
    check_range("bounce_hold_rises", rises, 1, 1);
    repeat (8) begin
      @(posedge clk); @(negedge clk);
      rises += int'(d_rise[1]);
    end
    check_range("bounce_hold_single", rises, 1, 1);

    // Mid-operation reset with levels high
    check("pre_rst_levels", d_lvl, 2'b11);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midrst_level",     d_lvl,  2'b00);
    check("midrst_fall",      d_fall, 2'b00);
    check("midrst_byp_level", b_lvl,  2'b00);
    check("midrst_byp_fall",  b_fall, 2'b00);
    rst = 1'b0;

    // Randomized stimulus; the per-cycle compare does the checking
    for (int n = 0; n < 1500; n++) begin
      v = W'($urandom);
      async_in = v;
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(10, 30)) @(negedge clk);
      else                           repeat ($urandom_range(1, 6))   @(negedge clk);
      rst = 1'b0;
    end
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
